// File: rtl/tank_sprite_scheduler_if.sv
// Bus between game logic / video timing / sprite ROM and the tank sprite scheduler.
// Optional macro TANK_SCHED_MIRROR_EN adds the wr_mirror table field.
interface tank_sprite_scheduler_if #(
    parameter int NUM_SPRITES = 4,
    parameter int NUM_FRAMES  = 8,
    parameter int ROM_AW      = 13
);
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int FR_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [FR_W-1:0]   wr_frame;
    logic              wr_vis;
`ifdef TANK_SCHED_MIRROR_EN
    logic              wr_mirror;
`endif
    // Commit handshake: commit_req is a one-cycle request, accepted only while idle
    // (commit_pending rises the next cycle); further requests while pending are absorbed.
    // commit_ack pulses for exactly the cycle on which shadow is copied to active.
    logic              commit_req;
    logic              commit_pending;
    logic              commit_ack;
    logic              commit_fsm_state;
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_q;
    logic              pix_valid;
    logic [3:0]        pix_index;
    logic [SEL_W-1:0]  pix_sel;

    modport master (
        output DrawX, DrawY, blank, wr_en, wr_sel, wr_x, wr_y, wr_frame, wr_vis,
`ifdef TANK_SCHED_MIRROR_EN
        output wr_mirror,
`endif
        output commit_req, rom_q,
        input  commit_pending, commit_ack, commit_fsm_state, rom_addr,
        input  pix_valid, pix_index, pix_sel
    );

    modport slave (
        input  DrawX, DrawY, blank, wr_en, wr_sel, wr_x, wr_y, wr_frame, wr_vis,
`ifdef TANK_SCHED_MIRROR_EN
        input  wr_mirror,
`endif
        input  commit_req, rom_q,
        output commit_pending, commit_ack, commit_fsm_state, rom_addr,
        output pix_valid, pix_index, pix_sel
    );
endinterface

// File: rtl/tank_sprite_scheduler.sv
// Shares one multi-frame tank sprite ROM between NUM_SPRITES tanks: hit test, priority, ROM address, palette index.
// Optional macro TANK_SCHED_MIRROR_EN adds a per-entry horizontal mirror bit.
module tank_sprite_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int NUM_FRAMES  = 8,
    parameter int ROM_AW      = 13,
    parameter int TRANSPARENT = 0,
    parameter int V_ACTIVE    = 480
) (
    input  logic                    vga_clk,
    input  logic                    reset,
    tank_sprite_scheduler_if.slave  bus
);
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int FR_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    typedef enum logic { IDLE = 1'b0, PENDING = 1'b1 } commit_state_t;

    commit_state_t state, state_next;
    logic          do_copy;
    logic          boundary;

    logic [9:0]      sh_x     [NUM_SPRITES];
    logic [9:0]      sh_y     [NUM_SPRITES];
    logic [FR_W-1:0] sh_frame [NUM_SPRITES];
    logic            sh_vis   [NUM_SPRITES];
    logic [9:0]      act_x    [NUM_SPRITES];
    logic [9:0]      act_y    [NUM_SPRITES];
    logic [FR_W-1:0] act_frame[NUM_SPRITES];
    logic            act_vis  [NUM_SPRITES];
`ifdef TANK_SCHED_MIRROR_EN
    logic            sh_mir   [NUM_SPRITES];
    logic            act_mir  [NUM_SPRITES];
    logic            win_mir;
`endif

    assign boundary = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_ACTIVE));

    always_ff @(posedge vga_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // The boundary decision uses the pre-edge state, so a request arriving on the
    // boundary cycle itself waits for the following frame.
    always_comb begin
        state_next = state;
        do_copy    = 1'b0;
        case (state)
            IDLE:    if (bus.commit_req) state_next = PENDING;
            PENDING: if (boundary) begin
                do_copy    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign bus.commit_pending   = (state == PENDING);
    assign bus.commit_ack       = do_copy && !reset;
    assign bus.commit_fsm_state = state;

    // Copy uses NBA-old shadow values, so a same-cycle write is not included.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]      <= '0;
                sh_y[i]      <= '0;
                sh_frame[i]  <= '0;
                sh_vis[i]    <= 1'b0;
                act_x[i]     <= '0;
                act_y[i]     <= '0;
                act_frame[i] <= '0;
                act_vis[i]   <= 1'b0;
`ifdef TANK_SCHED_MIRROR_EN
                sh_mir[i]    <= 1'b0;
                act_mir[i]   <= 1'b0;
`endif
            end
        end else begin
            if (bus.wr_en && (int'(bus.wr_sel) < NUM_SPRITES)) begin
                sh_x[bus.wr_sel]     <= bus.wr_x;
                sh_y[bus.wr_sel]     <= bus.wr_y;
                sh_frame[bus.wr_sel] <= bus.wr_frame;
                sh_vis[bus.wr_sel]   <= bus.wr_vis;
`ifdef TANK_SCHED_MIRROR_EN
                sh_mir[bus.wr_sel]   <= bus.wr_mirror;
`endif
            end
            if (do_copy) begin
                act_x     <= sh_x;
                act_y     <= sh_y;
                act_frame <= sh_frame;
                act_vis   <= sh_vis;
`ifdef TANK_SCHED_MIRROR_EN
                act_mir   <= sh_mir;
`endif
            end
        end
    end

    logic             hit;
    logic [SEL_W-1:0] win_sel;
    logic [10:0]      win_dx, win_dy, dx_eff, dxe, dye;
    logic [FR_W-1:0]  win_frame;
    logic [ROM_AW-1:0] addr_next;

    // Scan from the highest index down so the lowest hitting index overwrites last.
    always_comb begin
        hit       = 1'b0;
        win_sel   = '0;
        win_dx    = '0;
        win_dy    = '0;
        win_frame = '0;
        dxe       = '0;
        dye       = '0;
`ifdef TANK_SCHED_MIRROR_EN
        win_mir   = 1'b0;
`endif
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            dxe = {1'b0, bus.DrawX} - {1'b0, act_x[i]};
            dye = {1'b0, bus.DrawY} - {1'b0, act_y[i]};
            if (bus.blank && act_vis[i] && (bus.DrawX >= act_x[i]) && (bus.DrawY >= act_y[i]) &&
                (dxe < 11'(SPR_W)) && (dye < 11'(SPR_H))) begin
                hit       = 1'b1;
                win_sel   = SEL_W'(i);
                win_dx    = dxe;
                win_dy    = dye;
                win_frame = act_frame[i];
`ifdef TANK_SCHED_MIRROR_EN
                win_mir   = act_mir[i];
`endif
            end
        end
    end

`ifdef TANK_SCHED_MIRROR_EN
    assign dx_eff = win_mir ? (11'(SPR_W - 1) - win_dx) : win_dx;
`else
    assign dx_eff = win_dx;
`endif

    assign addr_next = hit ? (ROM_AW'(win_frame) * ROM_AW'(SPR_W * SPR_H) +
                              ROM_AW'(win_dy) * ROM_AW'(SPR_W) + ROM_AW'(dx_eff))
                           : '0;

    logic             hit_d1, hit_d2;
    logic [SEL_W-1:0] sel_d1, sel_d2;

    // hit/sel travel alongside the ROM access so they line up with rom_q.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            bus.rom_addr  <= '0;
            hit_d1        <= 1'b0;
            sel_d1        <= '0;
            hit_d2        <= 1'b0;
            sel_d2        <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_index <= '0;
            bus.pix_sel   <= '0;
        end else begin
            bus.rom_addr  <= addr_next;
            hit_d1        <= hit;
            sel_d1        <= win_sel;
            hit_d2        <= hit_d1;
            sel_d2        <= sel_d1;
            bus.pix_valid <= hit_d2 && (bus.rom_q != 4'(TRANSPARENT));
            bus.pix_index <= (hit_d2 && (bus.rom_q != 4'(TRANSPARENT))) ? bus.rom_q : 4'd0;
            bus.pix_sel   <= sel_d2;
        end
    end
endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Bench for tank_sprite_scheduler: vector table through a scoreboard plus commit/reset sequences.
// Build with TANK_SCHED_MIRROR_EN to also exercise the mirror field.
module tb_tank_sprite_scheduler;
    localparam int NUM_SPRITES = 4;
    localparam int NUM_FRAMES  = 8;
    localparam int ROM_AW      = 13;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    tank_sprite_scheduler_if #(.NUM_SPRITES(NUM_SPRITES), .NUM_FRAMES(NUM_FRAMES), .ROM_AW(ROM_AW)) bus();

    tank_sprite_scheduler #(.NUM_SPRITES(NUM_SPRITES), .NUM_FRAMES(NUM_FRAMES), .ROM_AW(ROM_AW)) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Sprite ROM model: one-cycle synchronous read
    logic [3:0] rom_mem [1 << ROM_AW];
    always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_addr];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: tokens track which cycles carry a checked pixel through the pipeline
    logic [12:0] addr_q[$];
    logic [6:0]  exp_q[$];
    logic [2:0]  tok = '0;
    logic        drv_tok = 1'b0;
    always @(posedge vga_clk) tok <= {tok[1:0], drv_tok};

    always @(negedge vga_clk) begin
        logic [12:0] a;
        logic [6:0]  e;
        if (tok[0]) begin
            if (addr_q.size() == 0) check("addr_q_empty", 1, 0);
            else begin
                a = addr_q.pop_front();
                check("rom_addr", int'(bus.rom_addr), int'(a));
            end
        end
        if (tok[2]) begin
            if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("pix_valid", int'(bus.pix_valid), int'(e[6]));
                check("pix_index", int'(bus.pix_index), int'(e[5:2]));
                check("pix_sel",   int'(bus.pix_sel),   int'(e[1:0]));
            end
        end
    end

    typedef struct {
        int x; int y; bit b; bit hit; int sel; int addr;
    } vec_t;
    vec_t tbl[20];

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.DrawX = 10'd5;
        bus.DrawY = 10'd5;
        bus.blank = 1'b0;
        drv_tok   = 1'b0;
    endtask

    task automatic write_entry(input int sel, input int x, input int y, input int fr, input bit vis);
        bus.wr_en    = 1'b1;
        bus.wr_sel   = 2'(sel);
        bus.wr_x     = 10'(x);
        bus.wr_y     = 10'(y);
        bus.wr_frame = 3'(fr);
        bus.wr_vis   = vis;
        step();
        bus.wr_en    = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        logic [3:0] idx;
        logic       vld;
        bus.DrawX = 10'(v.x);
        bus.DrawY = 10'(v.y);
        bus.blank = v.b;
        drv_tok   = 1'b1;
        idx = v.hit ? rom_mem[v.addr] : 4'd0;
        vld = v.hit && (idx != 4'd0);
        addr_q.push_back(13'(v.addr));
        exp_q.push_back({vld, idx, 2'(v.sel)});
        step();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply_vec(tbl[i]);
        idle_bus();
        repeat (4) step();
    endtask

    task automatic commit(input bit twice);
        bus.commit_req = 1'b1;
        @(negedge vga_clk);
        check("pending_before_req", int'(bus.commit_pending), 0);
        step();
        if (!twice) bus.commit_req = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd479;
        @(negedge vga_clk);
        check("pending_after_req", int'(bus.commit_pending), 1);
        check("ack_line479", int'(bus.commit_ack), 0);
        step();
        bus.commit_req = 1'b0;
        bus.DrawX = 10'd1;
        bus.DrawY = 10'd480;
        @(negedge vga_clk);
        check("ack_x1_y480", int'(bus.commit_ack), 0);
        step();
        bus.DrawX = 10'd0;
        @(negedge vga_clk);
        check("ack_boundary", int'(bus.commit_ack), 1);
        step();
        idle_bus();
        @(negedge vga_clk);
        check("pending_after_ack", int'(bus.commit_pending), 0);
        check("ack_single", int'(bus.commit_ack), 0);
        check("fsm_idle", int'(bus.commit_fsm_state), 0);
        step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pending"},   int'(bus.commit_pending), 0);
        check({tag, "_ack"},       int'(bus.commit_ack), 0);
        check({tag, "_rom_addr"},  int'(bus.rom_addr), 0);
        check({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
        check({tag, "_pix_index"}, int'(bus.pix_index), 0);
        check({tag, "_pix_sel"},   int'(bus.pix_sel), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 4'($urandom_range(1, 15));
        rom_mem[2149] = 4'd7;
        rom_mem[2049] = 4'd0;

        // phase 1: s0 {100,50,f2}
        tbl[0]  = '{105, 53, 1'b1, 1'b1, 0, 2149};
        tbl[1]  = '{ 99, 53, 1'b1, 1'b0, 0, 0};
        tbl[2]  = '{131, 81, 1'b1, 1'b1, 0, 3071};
        tbl[3]  = '{132, 60, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{100, 82, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{110, 60, 1'b0, 1'b0, 0, 0};
        tbl[6]  = '{101, 50, 1'b1, 1'b1, 0, 2049};
        // phase 2: s0 {190,195,f3} s1 {185,180,f1} s2 {620,100,f0} s3 {1020,470,f4}
        tbl[7]  = '{200, 200, 1'b1, 1'b1, 0, 3242};
        tbl[8]  = '{186, 181, 1'b1, 1'b1, 1, 1057};
        tbl[9]  = '{639, 110, 1'b1, 1'b1, 2, 339};
        tbl[10] = '{  0, 470, 1'b1, 1'b0, 0, 0};
        tbl[11] = '{  3, 475, 1'b1, 1'b0, 0, 0};
        tbl[12] = '{1023, 470, 1'b1, 1'b1, 3, 4099};
        tbl[13] = '{1023, 479, 1'b1, 1'b1, 3, 4387};
        tbl[14] = '{1023, 469, 1'b1, 1'b0, 0, 0};
        tbl[15] = '{1023, 480, 1'b0, 1'b0, 0, 0};
        // phase 3: s0 hidden in shadow only, then committed
        tbl[16] = '{200, 200, 1'b1, 1'b1, 0, 3242};
        tbl[17] = '{200, 200, 1'b1, 1'b1, 1, 1679};
        // s2 moved to {300,300,f5} while pending
        tbl[18] = '{301, 302, 1'b1, 1'b1, 2, 5185};
        // after reset: tables empty
        tbl[19] = '{200, 200, 1'b1, 1'b0, 0, 0};

        idle_bus();
        bus.wr_en      = 1'b0;
        bus.wr_sel     = '0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_frame   = '0;
        bus.wr_vis     = 1'b0;
`ifdef TANK_SCHED_MIRROR_EN
        bus.wr_mirror  = 1'b0;
`endif
        bus.commit_req = 1'b0;

        reset = 1'b1;
        repeat (3) step();
        @(negedge vga_clk);
        check_outputs_zero("reset");
        check("reset_fsm", int'(bus.commit_fsm_state), 0);
        step();
        reset = 1'b0;
        step();
        @(negedge vga_clk);
        check_outputs_zero("post_reset");

        write_entry(0, 100, 50, 2, 1'b1);
        commit(1'b0);
        run_rows(0, 6);

        write_entry(0, 190, 195, 3, 1'b1);
        write_entry(1, 185, 180, 1, 1'b1);
        write_entry(2, 620, 100, 0, 1'b1);
        write_entry(3, 1020, 470, 4, 1'b1);
        commit(1'b0);
        run_rows(7, 15);

        write_entry(0, 190, 195, 3, 1'b0);
        run_rows(16, 16);
        commit(1'b1);
        run_rows(17, 17);

        // request on the boundary cycle waits a frame; write while pending is copied
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd480;
        bus.commit_req = 1'b1;
        @(negedge vga_clk);
        check("ack_on_req_boundary", int'(bus.commit_ack), 0);
        step();
        bus.commit_req = 1'b0;
        idle_bus();
        @(negedge vga_clk);
        check("pending_after_boundary_req", int'(bus.commit_pending), 1);
        check("fsm_pending", int'(bus.commit_fsm_state), 1);
        write_entry(2, 300, 300, 5, 1'b1);
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd480;
        @(negedge vga_clk);
        check("ack_next_frame", int'(bus.commit_ack), 1);
        step();
        idle_bus();
        @(negedge vga_clk);
        check("pending_cleared", int'(bus.commit_pending), 0);
        run_rows(18, 18);

`ifdef TANK_SCHED_MIRROR_EN
        bus.wr_mirror = 1'b1;
        write_entry(0, 100, 50, 2, 1'b1);
        bus.wr_mirror = 1'b0;
        commit(1'b0);
        apply_vec('{105, 53, 1'b1, 1'b1, 0, 2170});
        idle_bus();
        repeat (4) step();
`endif

        // reset while pending drops the request
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
        @(negedge vga_clk);
        check("pending_before_reset", int'(bus.commit_pending), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge vga_clk);
        check_outputs_zero("reset_pending");
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd480;
        @(negedge vga_clk);
        check("no_ack_after_reset", int'(bus.commit_ack), 0);
        step();
        idle_bus();
        step();
        run_rows(19, 19);

        if (addr_q.size() != 0 || exp_q.size() != 0) check("scoreboard_drained", 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
